// File: rtl/vx_alu_pipe.sv
// ---------------------------------------------------------------------------
// vx_alu_pipe
//   Pipelined SIMD integer ALU for the execute stage. One warp-wide request
//   is accepted per cycle (valid/ready). Every lane gets a result. Branch
//   compare flags come from one selected lane. Results leave in order through
//   an elastic pipeline of LATENCY register stages with full backpressure.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   valid_in/ready_in request handshake (ready_in is combinational from ready_out)
//   op_in             4-bit opcode (see op_e)
//   lanemask_in       active lanes; inactive lanes produce 0
//   a_in, b_in        per-lane operands, lane i at [i*DATAW +: DATAW]
//   tag_in            opaque sideband, returned unchanged with the result
//   cmp_lane_in       lane that drives the compare flags (out of range -> lane 0)
//   valid_out/ready_out result handshake
//   result_out, lanemask_out, tag_out, cmp_eq_out, cmp_lt_out, cmp_ltu_out
// ---------------------------------------------------------------------------
module vx_alu_pipe #(
   parameter int NUM_LANES = 4,
   parameter int DATAW     = 32,
   parameter int LATENCY   = 2,
   parameter int TAGW      = 16,
   parameter int LANEW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_in,
   output logic                       ready_in,
   input  logic [3:0]                 op_in,
   input  logic [NUM_LANES-1:0]       lanemask_in,
   input  logic [NUM_LANES*DATAW-1:0] a_in,
   input  logic [NUM_LANES*DATAW-1:0] b_in,
   input  logic [TAGW-1:0]            tag_in,
   input  logic [LANEW-1:0]           cmp_lane_in,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [NUM_LANES*DATAW-1:0] result_out,
   output logic [NUM_LANES-1:0]       lanemask_out,
   output logic [TAGW-1:0]            tag_out,
   output logic                       cmp_eq_out,
   output logic                       cmp_lt_out,
   output logic                       cmp_ltu_out
);

   localparam int SHW  = $clog2(DATAW);
   localparam int RESW = NUM_LANES * DATAW;
   localparam logic [LANEW:0] LANE_LIMIT = (LANEW + 1)'(NUM_LANES);

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,  OP_SUB   = 4'd1,  OP_SLT   = 4'd2,  OP_SLTU  = 4'd3,
      OP_AND   = 4'd4,  OP_OR    = 4'd5,  OP_XOR   = 4'd6,  OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,  OP_SRA   = 4'd9,  OP_MIN   = 4'd10, OP_MAX   = 4'd11,
      OP_MINU  = 4'd12, OP_MAXU  = 4'd13, OP_PASSA = 4'd14, OP_PASSB = 4'd15
   } op_e;

   // Everything that travels down the pipeline with one op.
   typedef struct packed {
      logic [RESW-1:0]      result;
      logic [NUM_LANES-1:0] mask;
      logic [TAGW-1:0]      tag;
      logic                 eq;
      logic                 lt;
      logic                 ltu;
   } stage_t;

   // ------------------------------------------------------------------------
   // Per-lane ALU (combinational, feeds stage 1)
   // ------------------------------------------------------------------------
   logic [RESW-1:0]  alu_res;
   logic [DATAW-1:0] lane_a, lane_b, lane_r;
   logic [SHW-1:0]   lane_sh;

   always_comb begin : lane_alu
      // NOTE: every variable gets a value before any branch so no path
      // through this block can leave one unassigned and infer a latch.
      alu_res = '0;
      lane_a  = '0;
      lane_b  = '0;
      lane_r  = '0;
      lane_sh = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_a  = a_in[i*DATAW +: DATAW];
         lane_b  = b_in[i*DATAW +: DATAW];
         lane_sh = lane_b[SHW-1:0];   // upper bits of b never affect a shift
         case (op_e'(op_in))
            OP_ADD:   lane_r = lane_a + lane_b;
            OP_SUB:   lane_r = lane_a - lane_b;
            OP_SLT:   lane_r = DATAW'($signed(lane_a) < $signed(lane_b));
            OP_SLTU:  lane_r = DATAW'(lane_a < lane_b);
            OP_AND:   lane_r = lane_a & lane_b;
            OP_OR:    lane_r = lane_a | lane_b;
            OP_XOR:   lane_r = lane_a ^ lane_b;
            OP_SLL:   lane_r = lane_a << lane_sh;
            OP_SRL:   lane_r = lane_a >> lane_sh;
            OP_SRA:   lane_r = $unsigned($signed(lane_a) >>> lane_sh);
            // Strict comparisons so that equal operands select a.
            OP_MIN:   lane_r = ($signed(lane_b) < $signed(lane_a)) ? lane_b : lane_a;
            OP_MAX:   lane_r = ($signed(lane_b) > $signed(lane_a)) ? lane_b : lane_a;
            OP_MINU:  lane_r = (lane_b < lane_a) ? lane_b : lane_a;
            OP_MAXU:  lane_r = (lane_b > lane_a) ? lane_b : lane_a;
            OP_PASSA: lane_r = lane_a;
            OP_PASSB: lane_r = lane_b;
            default:  lane_r = lane_a;
         endcase
         alu_res[i*DATAW +: DATAW] = lanemask_in[i] ? lane_r : '0;
      end
   end

   // ------------------------------------------------------------------------
   // Compare-lane selection: ignores op and lane mask
   // ------------------------------------------------------------------------
   logic [LANEW-1:0] cmp_sel;
   logic [DATAW-1:0] cmp_a, cmp_b;

   always_comb begin : cmp_select
      cmp_sel = ({1'b0, cmp_lane_in} < LANE_LIMIT) ? cmp_lane_in : '0;
      cmp_a   = '0;
      cmp_b   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (cmp_sel == LANEW'(i)) begin
            cmp_a = a_in[i*DATAW +: DATAW];
            cmp_b = b_in[i*DATAW +: DATAW];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Elastic pipeline
   // ------------------------------------------------------------------------
   stage_t               stage_q [LATENCY];
   stage_t               stage_d [LATENCY];
   logic [LATENCY-1:0]   valid_q;
   logic [LATENCY-1:0]   valid_d;
   logic [LATENCY-1:0]   ready;

   // ready_k = ~valid_k | ready_(k+1), unrolled: stage k can move unless it and
   // every stage after it are full while the output is stalled. Written flat
   // so no signal depends on another bit of itself.
   for (genvar k = 0; k < LATENCY; k++) begin : g_ready
      assign ready[k] = ready_out | ~(&valid_q[LATENCY-1:k]);
   end

   always_comb begin : stage_inputs
      stage_d[0].result = alu_res;
      stage_d[0].mask   = lanemask_in;
      stage_d[0].tag    = tag_in;
      stage_d[0].eq     = (cmp_a == cmp_b);
      stage_d[0].lt     = ($signed(cmp_a) < $signed(cmp_b));
      stage_d[0].ltu    = (cmp_a < cmp_b);
      valid_d[0]        = valid_in;
      for (int k = 1; k < LATENCY; k++) begin
         stage_d[k] = stage_q[k-1];
         valid_d[k] = valid_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         // NOTE: the stage data registers are cleared too (not just the
         // valid bits) because the outputs must read 0 after reset.
         for (int k = 0; k < LATENCY; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < LATENCY; k++) begin
            if (ready[k]) begin
               // NOTE: non-blocking so each stage samples its predecessor's
               // value from before this edge; blocking would let an op fall
               // through several stages in one cycle.
               valid_q[k] <= valid_d[k];
               // Data only moves with a real op, so an emptied stage keeps
               // its last contents instead of toggling on bubbles.
               if (valid_d[k]) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end
      end
   end

   assign ready_in     = ready[0];
   assign valid_out    = valid_q[LATENCY-1];
   assign result_out   = stage_q[LATENCY-1].result;
   assign lanemask_out = stage_q[LATENCY-1].mask;
   assign tag_out      = stage_q[LATENCY-1].tag;
   assign cmp_eq_out   = stage_q[LATENCY-1].eq;
   assign cmp_lt_out   = stage_q[LATENCY-1].lt;
   assign cmp_ltu_out  = stage_q[LATENCY-1].ltu;

endmodule

// File: tb/tb_vx_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_vx_alu_pipe
//   Self-checking bench for vx_alu_pipe (NUM_LANES=4, DATAW=32, LATENCY=2).
//   Each accepted request pushes its expected result to a queue; a monitor
//   pops and compares whenever a result is handed off downstream.
// ---------------------------------------------------------------------------
module tb_vx_alu_pipe;

   localparam int NUM_LANES = 4;
   localparam int DATAW     = 32;
   localparam int LATENCY   = 2;
   localparam int TAGW      = 16;
   localparam int LANEW     = 2;

   typedef struct packed {
      logic [127:0] result;
      logic [3:0]   mask;
      logic [15:0]  tag;
      logic         eq;
      logic         lt;
      logic         ltu;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_in;
   logic         ready_in;
   logic [3:0]   op_in;
   logic [3:0]   lanemask_in;
   logic [127:0] a_in;
   logic [127:0] b_in;
   logic [15:0]  tag_in;
   logic [1:0]   cmp_lane_in;
   logic         valid_out;
   logic         ready_out;
   logic [127:0] result_out;
   logic [3:0]   lanemask_out;
   logic [15:0]  tag_out;
   logic         cmp_eq_out;
   logic         cmp_lt_out;
   logic         cmp_ltu_out;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t mon_e;

   vx_alu_pipe #(
      .NUM_LANES(NUM_LANES), .DATAW(DATAW), .LATENCY(LATENCY),
      .TAGW(TAGW), .LANEW(LANEW)
   ) dut (
      .clk(clk), .reset(reset),
      .valid_in(valid_in), .ready_in(ready_in),
      .op_in(op_in), .lanemask_in(lanemask_in),
      .a_in(a_in), .b_in(b_in), .tag_in(tag_in), .cmp_lane_in(cmp_lane_in),
      .valid_out(valid_out), .ready_out(ready_out),
      .result_out(result_out), .lanemask_out(lanemask_out), .tag_out(tag_out),
      .cmp_eq_out(cmp_eq_out), .cmp_lt_out(cmp_lt_out), .cmp_ltu_out(cmp_ltu_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: compares every handed-off result with the queue head.
   always @(negedge clk) begin
      if (!reset && valid_out && ready_out) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got tag=%h, required no output", tag_out);
         end else begin
            mon_e = sb.pop_front();
            if (result_out !== mon_e.result || lanemask_out !== mon_e.mask ||
                tag_out !== mon_e.tag || cmp_eq_out !== mon_e.eq ||
                cmp_lt_out !== mon_e.lt || cmp_ltu_out !== mon_e.ltu) begin
               bad++;
               $display("FAIL result tag=%h: got res=%h mask=%b tag=%h eq/lt/ltu=%b%b%b, required res=%h mask=%b tag=%h eq/lt/ltu=%b%b%b",
                        mon_e.tag, result_out, lanemask_out, tag_out, cmp_eq_out,
                        cmp_lt_out, cmp_ltu_out, mon_e.result, mon_e.mask, mon_e.tag,
                        mon_e.eq, mon_e.lt, mon_e.ltu);
            end
         end
      end
   end

   function automatic logic [127:0] rep(input logic [31:0] x);
      return {4{x}};
   endfunction

   function automatic exp_t mk_exp(input logic [127:0] res, input logic [3:0] mask,
                                   input logic [15:0] tag, input logic eq,
                                   input logic lt, input logic ltu);
      exp_t e;
      e.result = res; e.mask = mask; e.tag = tag;
      e.eq = eq; e.lt = lt; e.ltu = ltu;
      return e;
   endfunction

   // Reference model for the opcode sweep.
   function automatic exp_t model(input logic [3:0] op, input logic [3:0] mask,
                                  input logic [127:0] a, input logic [127:0] b,
                                  input logic [15:0] tag, input logic [1:0] lane);
      exp_t        e;
      logic [31:0] x, y, r;
      logic [4:0]  s;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         x = a[i*32 +: 32];
         y = b[i*32 +: 32];
         s = y[4:0];
         case (op)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = {31'b0, $signed(x) < $signed(y)};
            4'd3:  r = {31'b0, x < y};
            4'd4:  r = x & y;
            4'd5:  r = x | y;
            4'd6:  r = x ^ y;
            4'd7:  r = x << s;
            4'd8:  r = x >> s;
            4'd9:  r = $signed(x) >>> s;
            4'd10: r = ($signed(x) <= $signed(y)) ? x : y;
            4'd11: r = ($signed(x) >= $signed(y)) ? x : y;
            4'd12: r = (x <= y) ? x : y;
            4'd13: r = (x >= y) ? x : y;
            4'd14: r = x;
            default: r = y;
         endcase
         e.result[i*32 +: 32] = mask[i] ? r : 32'h0;
      end
      x = a[lane*32 +: 32];
      y = b[lane*32 +: 32];
      e.mask = mask; e.tag = tag;
      e.eq = (x == y); e.lt = ($signed(x) < $signed(y)); e.ltu = (x < y);
      return e;
   endfunction

   // Drive one request, hold it until accepted (bounded), then push expectation.
   task automatic send(input logic [3:0] op, input logic [3:0] mask,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic [15:0] tag, input logic [1:0] lane, input exp_t e);
      int waited = 0;
      @(negedge clk);
      valid_in = 1'b1; op_in = op; lanemask_in = mask;
      a_in = a; b_in = b; tag_in = tag; cmp_lane_in = lane;
      while (!ready_in && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!ready_in) begin
         total++; bad++;
         $display("FAIL accept_timeout tag=%h: ready_in=%b, required 1", tag, ready_in);
         valid_in = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(e);
      #1 valid_in = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d ops still pending, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
      op_in = '0; lanemask_in = '0; a_in = '0; b_in = '0; tag_in = '0; cmp_lane_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({valid_out, result_out, lanemask_out, tag_out, cmp_eq_out, cmp_lt_out, cmp_ltu_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b res=%h mask=%b tag=%h, required all 0",
                  valid_out, result_out, lanemask_out, tag_out);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total++;
      if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got ready_in=%b valid_out=%b, required 1/0", ready_in, valid_out);
      end
   endtask

   task automatic test_add_latency();
      int n = 0;
      send(4'd0, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1), 16'h0011, 2'd0,
           mk_exp(128'h0, 4'hF, 16'h0011, 1'b0, 1'b1, 1'b0));
      while (!valid_out && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      // Edges after the accepting edge until valid_out rises.
      total++;
      if (n != LATENCY - 1) begin
         bad++;
         $display("FAIL add_latency: got %0d extra edges, required %0d", n, LATENCY - 1);
      end
      drain();
   endtask

   task automatic test_shifts();
      send(4'd9, 4'hF, rep(32'h8000_0000), rep(32'd4), 16'h0021, 2'd0,
           mk_exp(rep(32'hF800_0000), 4'hF, 16'h0021, 1'b0, 1'b1, 1'b0));
      send(4'd8, 4'hF, rep(32'h8000_0000), rep(32'd4), 16'h0022, 2'd1,
           mk_exp(rep(32'h0800_0000), 4'hF, 16'h0022, 1'b0, 1'b1, 1'b0));
      send(4'd7, 4'hF, rep(32'h3), rep(32'd33), 16'h0023, 2'd3,
           mk_exp(rep(32'h6), 4'hF, 16'h0023, 1'b0, 1'b1, 1'b1));
      drain();
   endtask

   task automatic test_minmax_mask();
      send(4'd10, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1), 16'h0031, 2'd0,
           mk_exp(rep(32'hFFFF_FFFF), 4'hF, 16'h0031, 1'b0, 1'b1, 1'b0));
      send(4'd11, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1), 16'h0032, 2'd0,
           mk_exp(rep(32'h1), 4'hF, 16'h0032, 1'b0, 1'b1, 1'b0));
      send(4'd12, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1), 16'h0033, 2'd0,
           mk_exp(rep(32'h1), 4'hF, 16'h0033, 1'b0, 1'b1, 1'b0));
      send(4'd13, 4'hF, rep(32'hFFFF_FFFF), rep(32'h1), 16'h0034, 2'd0,
           mk_exp(rep(32'hFFFF_FFFF), 4'hF, 16'h0034, 1'b0, 1'b1, 1'b0));
      send(4'd12, 4'b0101, rep(32'hFFFF_FFFF), rep(32'h1), 16'h0035, 2'd0,
           mk_exp({32'h0, 32'h1, 32'h0, 32'h1}, 4'b0101, 16'h0035, 1'b0, 1'b1, 1'b0));
      drain();
   endtask

   task automatic test_compare();
      // Lanes other than 2 hold equal operands, so a wrong lane shows eq=1.
      send(4'd0, 4'hF, {32'h0, 32'd5, 32'h9, 32'h9}, {32'h0, 32'd7, 32'h9, 32'h9},
           16'h0041, 2'd2, mk_exp({32'h0, 32'd12, 32'd18, 32'd18}, 4'hF, 16'h0041, 1'b0, 1'b1, 1'b1));
      // Compare lane is masked off: its flags still count.
      send(4'd6, 4'b1011, {32'h1, 32'hFFFF_FFFF, 32'h4, 32'h4}, {32'h1, 32'h0, 32'h4, 32'h4},
           16'h0042, 2'd2, mk_exp(128'h0, 4'b1011, 16'h0042, 1'b0, 1'b1, 1'b0));
      drain();
   endtask

   task automatic test_all_ops();
      logic [127:0] a, b;
      logic [3:0]   m;
      logic [1:0]   l;
      for (int op = 0; op < 16; op++) begin
         a = {$urandom(), $urandom(), $urandom(), $urandom()};
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (op % 4 == 0) b[63:32] = a[63:32];   // equal operands in lane 1
         m = 4'($urandom_range(1, 15));
         l = 2'($urandom_range(0, 3));
         send(4'(op), m, a, b, 16'(16'h0100 + op), l, model(4'(op), m, a, b, 16'(16'h0100 + op), l));
      end
      drain();
   endtask

   task automatic test_back_to_back_stall();
      logic [127:0] snap_res;
      logic [15:0]  snap_tag;
      logic [3:0]   snap_mask;
      logic [2:0]   snap_flags;
      logic         have_snap = 1'b0;
      fork
         begin
            for (int t = 1; t <= 6; t++) begin
               send(4'd0, 4'hF, rep(32'(t)), rep(32'h1), 16'(t), 2'd0,
                    model(4'd0, 4'hF, rep(32'(t)), rep(32'h1), 16'(t), 2'd0));
            end
         end
         begin
            @(posedge clk);
            #1 ready_out = 1'b0;
            repeat (5) begin
               @(negedge clk);
               total++;
               if (ready_in !== (sb.size() < LATENCY)) begin
                  bad++;
                  $display("FAIL stall_ready_in: got %b with %0d held, required %b",
                           ready_in, sb.size(), sb.size() < LATENCY);
               end
               if (valid_out) begin
                  if (have_snap) begin
                     total++;
                     if (result_out !== snap_res || tag_out !== snap_tag ||
                         lanemask_out !== snap_mask ||
                         {cmp_eq_out, cmp_lt_out, cmp_ltu_out} !== snap_flags) begin
                        bad++;
                        $display("FAIL stall_stable: got tag=%h res=%h, required tag=%h res=%h",
                                 tag_out, result_out, snap_tag, snap_res);
                     end
                  end else begin
                     snap_res   = result_out;
                     snap_tag   = tag_out;
                     snap_mask  = lanemask_out;
                     snap_flags = {cmp_eq_out, cmp_lt_out, cmp_ltu_out};
                     have_snap  = 1'b1;
                  end
               end
            end
            @(posedge clk);
            #1 ready_out = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_reset_inflight();
      ready_out = 1'b0;
      send(4'd14, 4'hF, rep(32'hA1A1_A1A1), rep(32'h5), 16'h00A1, 2'd0,
           model(4'd14, 4'hF, rep(32'hA1A1_A1A1), rep(32'h5), 16'h00A1, 2'd0));
      send(4'd15, 4'hF, rep(32'h7), rep(32'hA2A2_A2A2), 16'h00A2, 2'd1,
           model(4'd15, 4'hF, rep(32'h7), rep(32'hA2A2_A2A2), 16'h00A2, 2'd1));
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({valid_out, result_out, lanemask_out, tag_out, cmp_eq_out, cmp_lt_out, cmp_ltu_out} !== '0) begin
         bad++;
         $display("FAIL reset_inflight: got valid=%b res=%h mask=%b tag=%h, required all 0",
                  valid_out, result_out, lanemask_out, tag_out);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      ready_out = 1'b1;
      @(negedge clk);
      total++;
      if (ready_in !== 1'b1) begin
         bad++;
         $display("FAIL reset_inflight_ready: got ready_in=%b, required 1", ready_in);
      end
      // Any stale op appearing here is caught by the monitor as unexpected.
      repeat (10) @(negedge clk);
      drain();
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_shifts();
      test_minmax_mask();
      test_compare();
      test_all_ops();
      test_back_to_back_stall();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vx_alu_pipe.md
Name: vx_alu_pipe

Overview:
Parametrised, pipelined SIMD integer ALU for the execute stage. It accepts one warp-wide request per cycle through a valid/ready handshake and computes a per-lane result for all NUM_LANES lanes. It also produces branch-compare flags for one selected lane. Results leave through an elastic pipeline of LATENCY register stages with full backpressure, in order.

Parameters:
NUM_LANES, 4, number of SIMD lanes (>=1)
DATAW, 32, lane data width (power of 2, >=8)
LATENCY, 2, register stages from accept to valid_out (>=1)
TAGW, 16, width of opaque sideband tag (uuid/wid/rd/wb) carried alongside the data
LANEW, max(1,clog2(NUM_LANES)), width of the compare lane index

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_in  in  1  request valid
ready_in  out  1  request accepted when valid_in && ready_in
op_in  in  4  operation code
lanemask_in  in  NUM_LANES  active lanes
a_in  in  NUM_LANES*DATAW  operand A per lane (lane i at bits [i*DATAW +: DATAW])
b_in  in  NUM_LANES*DATAW  operand B per lane
tag_in  in  TAGW  sideband, returned unchanged
cmp_lane_in  in  LANEW  lane used for compare flags
valid_out  out  1  result valid
ready_out  in  1  downstream ready
result_out  out  NUM_LANES*DATAW  per-lane result
lanemask_out  out  NUM_LANES  lanemask_in of this op
tag_out  out  TAGW  tag_in of this op
cmp_eq_out  out  1  a==b on compare lane
cmp_lt_out  out  1  signed a<b on compare lane
cmp_ltu_out  out  1  unsigned a<b on compare lane

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Opcodes:
  - 0 ADD; 1 SUB; 2 SLT; 3 SLTU; 4 AND; 5 OR; 6 XOR.
  - 7 SLL; 8 SRL; 9 SRA.
  - 10 MIN; 11 MAX (signed); 12 MINU; 13 MAXU (unsigned).
  - 14 PASSA (returns a); 15 PASSB (returns b).
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^DATAW.
  - SLT and SLTU return zero-extended 1 or 0.
  - Shift amount = b[clog2(DATAW)-1:0]; upper bits of b are ignored.
  - SRA replicates the sign bit.
  - MIN/MAX on equal operands return a.
- Lane masking: lanes with lanemask_in[i]=0 output 0 on result_out.
- Compare flags are computed from the compare lane regardless of op and of that lane's mask bit.
  - cmp_lane_in >= NUM_LANES selects lane 0.
- Datapath timing:
  - Computation is combinational from the inputs and captured into stage 1.
  - Stages 2..LATENCY are pure registers.
  - With no stall, an op accepted in cycle T is presented with valid_out=1 in cycle T+LATENCY.
- Elastic handshake:
  - Each stage k has a valid bit; ready_k = ~valid_k || ready_(k+1).
  - The last stage uses ready_out; ready_in = ready_1.
  - Full throughput is one op per cycle; a bubble in any stage is collapsed by upstream advancement.
  - ready_in is combinational from ready_out; no combinational path from valid_in to valid_out.
- Stall: while valid_out && !ready_out, all output ports hold stable.
  - Ops are never dropped, duplicated or reordered.
  - Up to LATENCY ops are in flight.
- valid_in && !ready_in: the request is not captured; the upstream must hold it.
- Reset:
  - All stage valid bits are cleared, so valid_out=0 in the cycle after reset is asserted.
  - All data/tag/flag registers clear to 0; result_out, lanemask_out, tag_out and the cmp flags read 0.
  - ready_in=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight op; no stale op emerges afterwards.
- Simultaneous accept and retire in one cycle with the pipeline full: allowed, occupancy unchanged.

Test Plan:
- NUM_LANES=4, DATAW=32. ADD a=0xFFFFFFFF, b=1, mask=4'b1111 -> result 0 in all lanes; valid_out exactly LATENCY cycles after accept.
- Shifts, a=0x80000000, b=4 -> SRA 0xF8000000, SRL 0x08000000. SLL with b=33 -> shift by 1.
- Min/max, a=0xFFFFFFFF, b=1 -> MIN 0xFFFFFFFF, MINU 1, MAXU 0xFFFFFFFF. Mask 4'b0101 -> lanes 1 and 3 read 0; lanemask_out=4'b0101.
- Compare, cmp_lane_in=2, lane2 a=5, b=7 -> eq=0, lt=1, ltu=1. Lane2 a=0xFFFFFFFF, b=0 -> lt=1, ltu=0.
- Backpressure, LATENCY=2: stream tags 1..6 with ready_out low for 5 cycles -> ready_in drops once 2 ops are held; outputs are stable while stalled; tags emerge 1..6 in order, each exactly once.
- Reset asserted with 2 ops in flight -> valid_out=0 next cycle, all outputs 0, ready_in=1 after release, no stale tag ever appears.
